// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
//
// Multi-cycle control unit for the MIPS core. A registered state machine
// sequences FETCH -> DECODE -> EXEC -> MEM -> WB (plus BRANCH and JUMP) and
// drives the PC, IR, RF, EXT, ALU, mux and data-memory strobes. Instruction
// and data memories may stretch FETCH and MEM with their ready signals. A wait
// counter sends the unit to a sticky ERR state when a memory never answers.
// An unknown opcode also goes to ERR. Only rst leaves ERR.
//
// Optional feature macro: MC_JUMP_EN
//   defined   : jal and jr are decoded and executed in JUMP
//   undefined : jal and jr are illegal and go to ERR; only j uses JUMP
//
// Parameters:
//   ALUOP_W   ALUOp width (ADD=0, SUB=1, OR=2, LUI=3; upper bits zero)
//   WAIT_W    width of the memory wait counter
//   MAX_WAIT  wait cycles tolerated before ERR (must fit in WAIT_W bits)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Op, Funct         IR[31:26] and IR[5:0]
//   Zero              ALU zero flag (used in BRANCH)
//   im_ready/dm_ready instruction / data memory handshake
//   im_req/dm_req     memory requests
//   PCWr IRWr RFWr DMWr   write strobes
//   EXTOp ALUOp NPCOp BSel WDSel A3Sel   datapath selects
//   err               sticky error flag
//   state_o           current state, for debug
// -----------------------------------------------------------------------------
module mips_mc_ctrl #(
    parameter int ALUOP_W  = 2,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               im_ready,
    input  logic               dm_ready,
    output logic               im_req,
    output logic               dm_req,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RFWr,
    output logic               DMWr,
    output logic [1:0]         EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic               BSel,
    output logic [1:0]         WDSel,
    output logic [1:0]         A3Sel,
    output logic               err,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE  = 4'd0,
        C_ADDU  = 4'd1,
        C_SUBU  = 4'd2,
        C_ORI   = 4'd3,
        C_ADDIU = 4'd4,
        C_LUI   = 4'd5,
        C_LW    = 4'd6,
        C_SW    = 4'd7,
        C_BEQ   = 4'd8,
        C_J     = 4'd9,
        C_JAL   = 4'd10,
        C_JR    = 4'd11
    } class_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    class_t            class_q, class_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    class_t            dec_class;
    logic [1:0]        alu_code;

    // Instruction classification, only consumed while in DECODE.
    always_comb begin
        dec_class = C_NONE;
        case (Op)
            6'b000000: begin
                case (Funct)
                    6'b100001: dec_class = C_ADDU;
                    6'b100011: dec_class = C_SUBU;
`ifdef MC_JUMP_EN
                    6'b001000: dec_class = C_JR;
`endif
                    default:   dec_class = C_NONE;
                endcase
            end
            6'b001101: dec_class = C_ORI;
            6'b001001: dec_class = C_ADDIU;
            6'b001111: dec_class = C_LUI;
            6'b100011: dec_class = C_LW;
            6'b101011: dec_class = C_SW;
            6'b000100: dec_class = C_BEQ;
            6'b000010: dec_class = C_J;
`ifdef MC_JUMP_EN
            6'b000011: dec_class = C_JAL;
`endif
            default:   dec_class = C_NONE;
        endcase
    end

    // Next-state, class and wait-counter logic. The counter is cleared on
    // every ready and whenever FETCH/MEM is (re)entered, so reaching
    // WAIT_LIMIT without ready always lands in ERR before it could wrap.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (im_ready) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                case (dec_class)
                    C_BEQ:              state_d = S_BRANCH;
                    C_J, C_JAL, C_JR:   state_d = S_JUMP;
                    C_NONE:             state_d = S_ERR;
                    default:            state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (class_q == C_LW || class_q == C_SW) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dm_ready) begin
                    state_d = (class_q == C_SW) ? S_FETCH : S_WB;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            class_q <= C_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs decode from registered state/class; FETCH strobes also follow
    // the same-cycle im_ready so the IR/PC load on the accepting edge.
    always_comb begin
        im_req   = 1'b0;
        dm_req   = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        EXTOp    = 2'b00;
        alu_code = 2'd0;
        NPCOp    = 2'b00;
        BSel     = 1'b0;
        WDSel    = 2'b00;
        A3Sel    = 2'b00;
        err      = 1'b0;
        case (state_q)
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
            end
            S_EXEC: begin
                case (class_q)
                    C_ADDU:  alu_code = 2'd0;
                    C_SUBU:  alu_code = 2'd1;
                    C_ORI: begin
                        alu_code = 2'd2;
                        BSel     = 1'b1;
                        EXTOp    = 2'b00;
                    end
                    C_LUI: begin
                        alu_code = 2'd3;
                        BSel     = 1'b1;
                        EXTOp    = 2'b10;
                    end
                    C_ADDIU, C_LW, C_SW: begin
                        alu_code = 2'd0;
                        BSel     = 1'b1;
                        EXTOp    = 2'b01;
                    end
                    default: alu_code = 2'd0;
                endcase
            end
            S_MEM: begin
                dm_req = 1'b1;
                DMWr   = (class_q == C_SW);
            end
            S_WB: begin
                RFWr  = 1'b1;
                A3Sel = (class_q == C_ADDU || class_q == C_SUBU) ? 2'b01 : 2'b00;
                WDSel = (class_q == C_LW) ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alu_code = 2'd1;
                NPCOp    = 2'b01;
                PCWr     = Zero;
            end
            S_JUMP: begin
                PCWr = 1'b1;
                case (class_q)
                    C_JAL: begin
                        NPCOp = 2'b10;
                        RFWr  = 1'b1;
                        A3Sel = 2'b10;
                        WDSel = 2'b10;
                    end
                    C_JR:    NPCOp = 2'b11;
                    default: NPCOp = 2'b10;
                endcase
            end
            S_ERR:   err = 1'b1;
            default: err = 1'b0;
        endcase
    end

    assign ALUOp   = ALUOP_W'(alu_code);
    assign state_o = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
//
// Directed and random instruction sequences for mips_mc_ctrl. For each
// instruction the bench derives the expected per-cycle output bundle from the
// instruction's kind and the memory wait lengths it chose, then compares the
// DUT bundle every cycle. Inputs that must be ignored (Op/Funct outside
// DECODE, ready outside its state, Zero outside BRANCH) are randomized.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    localparam int MAXW = 15;

    // Instruction kinds as seen by the programmer.
    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_ADDIU = 3, K_LUI = 4,
                   K_LW = 5, K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9,
                   K_JR = 10, K_BAD = 11;

    typedef struct packed {
        logic       im_req;
        logic       dm_req;
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       dmwr;
        logic [1:0] extop;
        logic [1:0] aluop;
        logic [1:0] npcop;
        logic       bsel;
        logic [1:0] wdsel;
        logic [1:0] a3sel;
        logic       err;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, im_ready, dm_ready;
    logic       im_req, dm_req, PCWr, IRWr, RFWr, DMWr, BSel, err;
    logic [1:0] EXTOp, ALUOp, NPCOp, WDSel, A3Sel;
    logic [2:0] state_o;
    obs_t       obs;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mc_ctrl #(.ALUOP_W(2), .WAIT_W(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .im_req(im_req), .dm_req(dm_req), .PCWr(PCWr), .IRWr(IRWr),
        .RFWr(RFWr), .DMWr(DMWr), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .NPCOp(NPCOp), .BSel(BSel), .WDSel(WDSel), .A3Sel(A3Sel),
        .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {im_req, dm_req, PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp,
                  NPCOp, BSel, WDSel, A3Sel, err, state_o};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        int k;
        k = K_BAD;
        case (op)
            6'b000000: begin
                if (fn == 6'b100001) k = K_ADDU;
                else if (fn == 6'b100011) k = K_SUBU;
`ifdef MC_JUMP_EN
                else if (fn == 6'b001000) k = K_JR;
`endif
            end
            6'b001101: k = K_ORI;
            6'b001001: k = K_ADDIU;
            6'b001111: k = K_LUI;
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000010: k = K_J;
`ifdef MC_JUMP_EN
            6'b000011: k = K_JAL;
`endif
            default:   k = K_BAD;
        endcase
        return k;
    endfunction

    // Baseline bundle for a state: every strobe low, im_req only in FETCH,
    // err only in ERR.
    function automatic obs_t mk(input int st);
        obs_t o;
        o        = '0;
        o.st     = 3'(st);
        o.im_req = (st == 0);
        o.err    = (st == 7);
        return o;
    endfunction

    task automatic check(input obs_t exp, input string tag);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply handshake inputs, check, advance to next negedge.
    task automatic cyc(input logic imr, input logic dmr, input obs_t exp, input string tag);
        im_ready = imr;
        dm_ready = dmr;
        #1;
        check(exp, tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        im_ready = 1'b1;
        dm_ready = 1'b1;
        Op       = 6'($urandom);
        @(negedge clk);
        rst      = 1'b0;
        im_ready = 1'b0;
        dm_ready = 1'b0;
        #1;
        check(mk(0), {tag, ":reset"});
        $display("[TB] %s: reset back to FETCH", tag);
    endtask

    task automatic err_tail(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            Op    = 6'($urandom);
            Funct = 6'($urandom);
            Zero  = 1'($urandom);
            cyc(1'($urandom), 1'($urandom), mk(7), {tag, ":err"});
        end
        do_reset(tag);
    endtask

    // Runs one instruction from FETCH and checks every cycle. imw/dmw are the
    // number of not-ready cycles before the memory answers; beyond MAXW the
    // memory never answers in time and ERR is expected.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int imw, input int dmw, input int err_cycles,
                            input string tag);
        int   k;
        int   nw;
        obs_t e;
        k = kind_of(op, fn);
        $display("[TB] %s: op=%b funct=%b zero=%0d im_wait=%0d dm_wait=%0d kind=%0d",
                 tag, op, fn, z, imw, dmw, k);
        nw = (imw > MAXW) ? MAXW + 1 : imw;
        for (int w = 0; w < nw; w++) begin
            Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
            cyc(1'b0, 1'($urandom), mk(0), {tag, ":fetch_wait"});
        end
        if (imw > MAXW) begin
            err_tail(tag, err_cycles);
            return;
        end
        e = mk(0); e.pcwr = 1'b1; e.irwr = 1'b1;
        Op = 6'($urandom); Funct = 6'($urandom);
        cyc(1'b1, 1'($urandom), e, {tag, ":fetch"});

        Op = op; Funct = fn; Zero = 1'($urandom);
        cyc(1'($urandom), 1'($urandom), mk(1), {tag, ":decode"});
        if (k == K_BAD) begin
            err_tail(tag, err_cycles);
            return;
        end

        if (k == K_BEQ) begin
            Zero = z;
            e = mk(5); e.aluop = 2'd1; e.npcop = 2'b01; e.pcwr = z;
            cyc(1'($urandom), 1'($urandom), e, {tag, ":branch"});
        end else if (k == K_J || k == K_JAL || k == K_JR) begin
            Zero = 1'($urandom);
            e = mk(6); e.pcwr = 1'b1;
            e.npcop = (k == K_JR) ? 2'b11 : 2'b10;
            if (k == K_JAL) begin
                e.rfwr = 1'b1; e.a3sel = 2'b10; e.wdsel = 2'b10;
            end
            cyc(1'($urandom), 1'($urandom), e, {tag, ":jump"});
        end else begin
            e = mk(2);
            case (k)
                K_SUBU:  e.aluop = 2'd1;
                K_ORI:   begin e.aluop = 2'd2; e.bsel = 1'b1; e.extop = 2'b00; end
                K_LUI:   begin e.aluop = 2'd3; e.bsel = 1'b1; e.extop = 2'b10; end
                K_ADDIU, K_LW, K_SW: begin e.bsel = 1'b1; e.extop = 2'b01; end
                default: e.aluop = 2'd0;
            endcase
            cyc(1'($urandom), 1'($urandom), e, {tag, ":exec"});
            if (k == K_LW || k == K_SW) begin
                e = mk(3); e.dm_req = 1'b1; e.dmwr = (k == K_SW);
                nw = (dmw > MAXW) ? MAXW + 1 : dmw;
                for (int w = 0; w < nw; w++)
                    cyc(1'($urandom), 1'b0, e, {tag, ":mem_wait"});
                if (dmw > MAXW) begin
                    err_tail(tag, err_cycles);
                    return;
                end
                cyc(1'($urandom), 1'b1, e, {tag, ":mem"});
            end
            if (k != K_SW) begin
                e = mk(4); e.rfwr = 1'b1;
                e.a3sel = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                e.wdsel = (k == K_LW) ? 2'b01 : 2'b00;
                cyc(1'($urandom), 1'($urandom), e, {tag, ":wb"});
            end
        end
        // Instruction must hand back to FETCH with a fresh wait budget.
        im_ready = 1'b0;
        #1;
        check(mk(0), {tag, ":back_to_fetch"});
    endtask

    initial begin
        obs_t       e;
        logic [5:0] rop, rfn;
        int         sel, imw, dmw;

        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check(mk(0), "reset");
        $display("[TB] reset: state FETCH, only im_req high");

        // Directed sequence.
        do_instr(6'b000000, 6'b100001, 1'b0, 0, 0, 0, "addu");
        do_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 0, "lw_dm3");
        do_instr(6'b101011, 6'b000000, 1'b0, 1, 2, 0, "sw");
        do_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 0, "beq_z1");
        do_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 0, "beq_z0");
        do_instr(6'b000000, 6'b100001, 1'b0, 16, 0, 3, "im_timeout");
        do_instr(6'b001101, 6'b000000, 1'b0, 14, 0, 0, "im_ready_15th");
        do_instr(6'b001001, 6'b000000, 1'b0, 15, 0, 0, "im_ready_16th");
        do_instr(6'b100011, 6'b000000, 1'b0, 0, 15, 0, "dm_ready_16th");
        do_instr(6'b101011, 6'b000000, 1'b0, 0, 16, 3, "dm_timeout");
        do_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 20, "illegal_op");
        do_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 3, "jal");
        do_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 3, "jr");
        do_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 0, "j");

        // Reset in the middle of MEM with dm_ready high must still win.
        Op = 6'b100011; Funct = 6'($urandom);
        e = mk(0); e.pcwr = 1'b1; e.irwr = 1'b1;
        cyc(1'b1, 1'b0, e, "rst_mem:fetch");
        cyc(1'b0, 1'b0, mk(1), "rst_mem:decode");
        e = mk(2); e.bsel = 1'b1; e.extop = 2'b01;
        cyc(1'b0, 1'b0, e, "rst_mem:exec");
        e = mk(3); e.dm_req = 1'b1;
        cyc(1'b0, 1'b0, e, "rst_mem:mem");
        do_reset("rst_mem");

        // Random instruction stream.
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 12);
            rfn = 6'($urandom);
            case (sel)
                0:  begin rop = 6'b000000; rfn = 6'b100001; end
                1:  begin rop = 6'b000000; rfn = 6'b100011; end
                2:  rop = 6'b001101;
                3:  rop = 6'b001001;
                4:  rop = 6'b001111;
                5:  rop = 6'b100011;
                6:  rop = 6'b101011;
                7:  rop = 6'b000100;
                8:  rop = 6'b000010;
                9:  rop = 6'b000011;
                10: begin rop = 6'b000000; rfn = 6'b001000; end
                11: rop = 6'b111111;
                default: rop = 6'($urandom);
            endcase
            imw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            dmw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            do_instr(rop, rfn, 1'($urandom), imw, dmw, 2, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS core. It replaces the single-cycle decode with a registered state machine that sequences fetch, decode, execute, memory and write-back. It drives the existing PC, IR, RF, EXT, ALU, mux and dm strobes, and handshakes with instruction and data memories that may take several cycles to respond. A watchdog flags a memory that never answers, and an unknown opcode drives the unit into a sticky error state.

## Interface
Parameters:
- ALUOP_W, default 2: ALUOp width. Encodings: ADD=0, SUB=1, OR=2, LUI=3; upper bits are zero.
- WAIT_W, default 4: width of the memory wait counter.
- MAX_WAIT, default 15: number of wait cycles tolerated before the error state. Must be ≤ 2^WAIT_W−1.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- Op, in, 6: IR[31:26].
- Funct, in, 6: IR[5:0].
- Zero, in, 1: ALU zero flag.
- im_ready, in, 1: instruction word valid this cycle.
- dm_ready, in, 1: data access complete this cycle.
- im_req, out, 1: instruction fetch request.
- dm_req, out, 1: data access request.
- PCWr, out, 1: PC load strobe.
- IRWr, out, 1: IR load strobe.
- RFWr, out, 1: register file write strobe.
- DMWr, out, 1: data memory write strobe.
- EXTOp, out, 2: extension mode. 00 zero, 01 signed, 10 shift-to-upper.
- ALUOp, out, ALUOP_W: ALU operation (encodings above).
- NPCOp, out, 2: next-PC source. 00 PC+4, 01 branch, 10 jump, 11 register.
- BSel, out, 1: ALU B input. 0 = RD2, 1 = Imm32.
- WDSel, out, 2: RF write data. 00 ALU, 01 DM, 10 PC+4.
- A3Sel, out, 2: RF write address. 00 rt, 01 rd, 10 $31.
- err, out, 1: sticky error flag.
- state_o, out, 3: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, ERR=7.
- FETCH:
  - im_req=1.
  - On im_ready: IRWr=1, PCWr=1 with NPCOp=00; go to DECODE.
  - Without im_ready: stay and count.
- DECODE:
  - Classify Op/Funct into an internal class register.
  - Supported instructions:
    - R-type (Op 000000) with addu (100001) or subu (100011)
    - ori (001101), addiu (001001), lui (001111)
    - lw (100011), sw (101011), beq (000100), j (000010)
    - jal (000011) and jr (Funct 001000) only when MC_JUMP_EN is defined
  - Routing: beq goes to BRANCH; j, jal and jr go to JUMP; ALU and memory classes go to EXEC; anything else goes to ERR.
- EXEC:
  - ALUOp/BSel/EXTOp per class: addu ADD/0; subu SUB/0; ori OR/1/00; addiu ADD/1/01; lui LUI/1/10; lw and sw ADD/1/01.
  - lw and sw go to MEM; all others go to WB.
- MEM:
  - dm_req=1 for the whole state; DMWr=1 for sw.
  - On dm_ready: lw goes to WB, sw goes to FETCH.
  - Without dm_ready: stay and count.
- WB:
  - RFWr=1 for exactly one cycle.
  - R-type: A3Sel=01, WDSel=00. ori/addiu/lui: A3Sel=00, WDSel=00. lw: A3Sel=00, WDSel=01.
  - Always go to FETCH.
- BRANCH: ALUOp=SUB, BSel=0, NPCOp=01, PCWr=Zero; go to FETCH.
- JUMP: PCWr=1.
  - j: NPCOp=10.
  - jal: NPCOp=10, RFWr=1, A3Sel=10, WDSel=10.
  - jr: NPCOp=11.
  - Go to FETCH.
- ERR: all strobes 0, err=1. Only rst exits.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on each ready.
  - Increments on each cycle that state is FETCH or MEM without ready.
  - When the counter equals MAX_WAIT and ready is still low, go to ERR next cycle.
  - No wrap-around is possible.
- Outputs not listed for a state are 0.
- At most one of PCWr/RFWr/DMWr rises per state, except FETCH (PCWr+IRWr) and jal (PCWr+RFWr).

## Timing
- Reset: next edge gives state FETCH, counter 0, class cleared, err=0, and every output 0 except im_req=1 and state_o=0.
- Outputs are combinational from registered state and class. PCWr/IRWr in FETCH and the state advance additionally depend on the same-cycle ready (Mealy).
- Cycle counts with zero-wait memories: R/I-type 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- Each wait cycle on im_ready or dm_ready adds one cycle.
- rst has priority over all transitions, including ERR, mid-MEM and a simultaneous ready. A pending sw asserted in the reset cycle is not guaranteed; the memory must qualify DMWr with rst.
- ready arriving on the MAX_WAIT cycle counts as success: the unit does not enter ERR.
- im_ready and dm_ready are ignored outside FETCH and MEM respectively.

## Configuration
- MC_JUMP_EN defined: jal and jr are decoded; NPCOp=11, A3Sel=10 and WDSel=10 become reachable.
- MC_JUMP_EN undefined: jal and jr decode as illegal and go to ERR; only j uses JUMP.

## Test plan
- Reset, then addu with im_ready tied high: states 0,1,2,4,0 over 4 cycles; RFWr=1 only in cycle 4 with A3Sel=01; PCWr/IRWr=1 in cycle 1.
- lw with dm_ready delayed 3 cycles: MEM held 4 cycles with dm_req=1; WB then has WDSel=01 and RFWr=1; total 8 cycles.
- beq with Zero=1, then beq with Zero=0: PCWr=1 and NPCOp=01 in BRANCH for the first; PCWr=0 for the second; each takes 3 cycles.
- im_ready held low: err=1 and state_o=7 after MAX_WAIT+1 wait cycles, i.e. 16 cycles at the default. A second run asserts im_ready on the 15th wait cycle: no error.
- Op=111111: ERR on the cycle after DECODE; strobes stay 0 for 20 cycles; rst returns to FETCH with err=0.
- jal with MC_JUMP_EN defined: JUMP cycle gives PCWr=1, RFWr=1, A3Sel=10, WDSel=10. Without the macro: ERR.
